md_sequencer: RTL and testbench
===============================

# md_sequencer

Multi-cycle sequencer for RV32M multiply/divide/remainder in the execute stage. It accepts an M-extension operation alongside the single-cycle ALU and iterates a radix-2 shift-add or restoring-divide datapath over DATA_WIDTH cycles. While it works, it holds the pipeline via `stall`, then presents the result for exactly one cycle.

## Interface
- `DATA_WIDTH`, 32, operand/result width; iteration count equals DATA_WIDTH.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  execute stage holds a valid M-extension instruction.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  DATA_WIDTH  rs1 value.
- `op_b`  in  DATA_WIDTH  rs2 value.
- `flush`  in  1  kill the in-flight operation (branch mispredict/trap).
- `stall`  out  1  freeze fetch/decode/execute registers.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  DATA_WIDTH  operation result.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - `start`=1 and `flush`=0: latch `op` and the operand magnitudes (per signedness), record operand signs, clear the 2·DATA_WIDTH accumulator and the iteration counter, then go to CALC.
- **CALC:**
  - One radix-2 step per cycle.
  - MUL*: conditional add of the multiplicand, then shift right.
  - DIV*/REM*: restoring subtract-compare, then shift left.
  - After DATA_WIDTH steps (counter reaches DATA_WIDTH-1), go to FIX.
- **FIX:** apply sign correction and select the result, then go to DONE.
  - MUL: low word.
  - MULH/MULHSU/MULHU: high word.
  - MUL/MULH/MULHSU: negate the 64-bit product if operand signs differ; MULHSU treats `op_b` as unsigned.
  - DIV: negate the quotient if the signs differ.
  - REM: the remainder takes the sign of the dividend.
  - Divide by zero overrides: DIV/DIVU = all ones; REM/REMU = `op_a` unmodified.
  - Overflow, DIV 0x80000000 / -1: falls out naturally as 0x80000000, and REM as 0. No special case.
- **DONE:** `done`=1, `result` valid, `stall`=0. Return to IDLE unconditionally.
  - A `start` seen in DONE belongs to the completed instruction, because the pipeline advances at this edge. It is ignored.
- **flush:**
  - In any state, go to IDLE at the next edge with no `done`.
  - flush has priority over `start` in the same cycle.
- **Reset:** state IDLE, `stall`=0, `busy`=0, `done`=0, `result`=0, counter=0, accumulator=0.
  - Reset mid-operation abandons the operation silently.
- **stall** is combinational: high in IDLE when `start`=1 and `flush`=0, and in CALC and FIX unless `flush`=1. Low in DONE.
- `result` holds its last value outside DONE.

## Timing
- `start` sampled in IDLE at cycle 0.
- CALC covers cycles 1..DATA_WIDTH.
- FIX is cycle DATA_WIDTH+1.
- DONE is cycle DATA_WIDTH+2, which is 34 for the default width.
- `stall` is high for cycles 0..DATA_WIDTH+1.
- Back-to-back M ops: the next `start` is sampled in IDLE at cycle DATA_WIDTH+3. No bubble beyond that.
- No combinational path from `op_a`/`op_b` to any output.

## Configuration
- **`MD_EARLY_OUT_EN`**
  - Defined: in IDLE, if `op_b`==0 (any op) or `op_a`==0 (MUL* only), skip CALC and go straight to FIX. `done` then arrives at cycle 2.
  - Undefined: every operation takes the full DATA_WIDTH+2 latency, and the results are identical.

## Structure
- Package `md_pkg`:
  - `md_op_t` enum over the eight funct3 encodings.
  - `md_state_t` enum {IDLE, CALC, FIX, DONE}.
  - Helper functions `is_div(op)` and `is_signed_a/b(op)`.
- One sub-module `md_step`: a combinational single radix-2 step.
  - Inputs: accumulator, operand, mode (mul/div).
  - Outputs: next accumulator and next quotient bit.
  - Instantiated once by `md_sequencer`, which owns the FSM, counter, sign logic and handshake.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3): `result`=0xFFFFFFEB and `done` at cycle 34; `stall` high for cycles 0..33.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD. REM of the same → 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM → 0.
- DIVU 5 / 0 → 0xFFFFFFFF. REM 0xFFFFFFFB / 0 → 0xFFFFFFFB. With `MD_EARLY_OUT_EN`, `done` at cycle 2; without it, at cycle 34.
- Flush at cycle 10 of a DIV → `busy`=0 and `stall`=0 next cycle, no `done` pulse. A new MUL `start` two cycles later completes normally. Repeat with `rst_n`=0 mid-CALC → all outputs 0.
- `start` held high across two consecutive MUL instructions (3×4, then 5×6) → `done` with 12 at cycle 34 and with 30 at cycle 69. No extra `done` from the held `start` in DONE.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared types and helpers for the RV32M multiply/divide sequencer.
// Holds the funct3 operation enum, FSM state enum and signedness helpers.
package md_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    function automatic logic is_div(md_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(md_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(md_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// md_sequencer_if: execute-stage <-> M-unit bundle.
// master = pipeline (start/op/op_a/op_b/flush), slave = sequencer (stall/busy/done/result).
interface md_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  flush;
    logic                  stall;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, op, op_a, op_b, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, op, op_a, op_b, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/md_step.sv
// md_step: one combinational radix-2 step (shift-add multiply or restoring divide).
// Ports: i_acc/i_operand/i_bit/i_div in; o_acc (next accumulator), o_qbit (quotient bit) out.
module md_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0] i_acc,
    input  logic [DATA_WIDTH-1:0]   i_operand,
    input  logic                    i_bit,
    input  logic                    i_div,
    output logic [2*DATA_WIDTH-1:0] o_acc,
    output logic                    o_qbit
);
    localparam int W = DATA_WIDTH;

    logic [W-1:0] w_addend;
    logic [W:0]   w_sum;
    logic [W:0]   w_rem;
    logic [W:0]   w_diff;

    always_comb begin
        w_addend = i_bit ? i_operand : '0;
        w_sum    = {1'b0, i_acc[2*W-1:W]} + {1'b0, w_addend};
        // divide: shift the next dividend bit into the partial remainder
        w_rem    = {i_acc[W-1:0], i_bit};
        w_diff   = w_rem - {1'b0, i_operand};
        o_qbit   = 1'b0;
        o_acc    = '0;
        if (i_div) begin
            // quotient slot (bit W) is left clear; the caller merges o_qbit
            o_qbit = ~w_diff[W];
            o_acc  = {i_acc[2*W-2:W], 1'b0,
                      (o_qbit ? w_diff[W-1:0] : w_rem[W-1:0])};
        end else begin
            o_acc  = {w_sum, i_acc[W-1:1]};
        end
    end
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle RV32M mul/div/rem unit; holds the pipeline via stall.
// Ports: clk, rst_n (sync, active-low), bus (md_sequencer_if.slave). Option: MD_EARLY_OUT_EN.
module md_sequencer
    import md_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    md_sequencer_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W-1);

    md_state_t      r_state, w_next;
    md_op_t         r_op, w_op;
    logic [W-1:0]   r_a, r_b, r_result;
    logic [2*W-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_sa, r_sb, r_bz;

    logic           w_go, w_sa, w_sb, w_skip, w_div, w_bit, w_qbit;
    logic [W-1:0]   w_mag_a, w_mag_b, w_fix, w_q, w_r, w_a_raw;
    logic [2*W-1:0] w_step_acc, w_acc_next, w_prod;

    assign w_op    = md_op_t'(bus.op);
    assign w_go    = bus.start & ~bus.flush;
    assign w_sa    = is_signed_a(w_op) & bus.op_a[W-1];
    assign w_sb    = is_signed_b(w_op) & bus.op_b[W-1];
    assign w_mag_a = w_sa ? -bus.op_a : bus.op_a;
    assign w_mag_b = w_sb ? -bus.op_b : bus.op_b;

`ifdef MD_EARLY_OUT_EN
    assign w_skip = (bus.op_b == '0) |
                    ((bus.op_a == '0) & ~is_div(w_op));
`else
    assign w_skip = 1'b0;
`endif

    // multiply walks op_b LSB-first; divide walks op_a MSB-first
    assign w_div = is_div(r_op);
    assign w_bit = w_div ? r_a[LAST - r_cnt] : r_b[r_cnt];

    md_step #(
        .DATA_WIDTH (W)
    ) u_step (
        .i_acc     (r_acc),
        .i_operand (w_div ? r_b : r_a),
        .i_bit     (w_bit),
        .i_div     (w_div),
        .o_acc     (w_step_acc),
        .o_qbit    (w_qbit)
    );

    assign w_acc_next = {w_step_acc[2*W-1:W+1],
                         w_step_acc[W] | w_qbit,
                         w_step_acc[W-1:0]};

    always_comb begin
        w_prod  = (r_sa ^ r_sb) ? -r_acc : r_acc;
        w_q     = (r_sa ^ r_sb) ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
        w_r     = r_sa ? -r_acc[W-1:0] : r_acc[W-1:0];
        w_a_raw = r_sa ? -r_a : r_a;
        w_fix   = '0;
        unique case (r_op)
            OP_MUL:                       w_fix = w_prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod[2*W-1:W];
            OP_DIV, OP_DIVU:              w_fix = r_bz ? '1 : w_q;
            OP_REM, OP_REMU:              w_fix = r_bz ? w_a_raw : w_r;
            default:                      w_fix = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_go) w_next = w_skip ? FIX : CALC;
            CALC: if (r_cnt == LAST) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (bus.flush) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_a      <= '0;
            r_b      <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_bz     <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_go) begin
                r_op  <= w_op;
                r_a   <= w_mag_a;
                r_b   <= w_mag_b;
                r_sa  <= w_sa;
                r_sb  <= w_sb;
                r_bz  <= (bus.op_b == '0);
                r_acc <= '0;
                r_cnt <= '0;
            end
            if (r_state == CALC) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == FIX && !bus.flush) begin
                r_result <= w_fix;
            end
        end
    end

    assign bus.stall  = (r_state == IDLE && w_go) ||
                        ((r_state == CALC || r_state == FIX) && !bus.flush);
    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed-vector bench for md_sequencer.
// Covers mul/div variants, divide by zero, overflow, flush, reset and back-to-back.
module tb_md_sequencer;
    import md_pkg::*;

`ifdef MD_EARLY_OUT_EN
    localparam int EO_CYC = 2;
`else
    localparam int EO_CYC = 34;
`endif

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    md_sequencer_if #(.DATA_WIDTH(32)) bus ();

    md_sequencer #(
        .DATA_WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_cyc);
        int cyc;
        int done_cyc;
        int stall_n;
        logic [31:0] res;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = f3;
        bus.op_a  = a;
        bus.op_b  = b;
        cyc = 0;
        done_cyc = -1;
        stall_n = 0;
        res = '0;
        #1;
        if (bus.stall) stall_n++;
        while (done_cyc < 0 && cyc < 100) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            cyc++;
            if (bus.done) begin
                done_cyc = cyc;
                res = bus.result;
                chk({tag, "_stall_at_done"}, 32'(bus.stall), 32'd0);
            end else if (bus.stall) begin
                stall_n++;
            end
        end
        chk({tag, "_res"}, res, exp_res);
        chk({tag, "_cyc"}, 32'(done_cyc), 32'(exp_cyc));
        chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(exp_cyc));
        @(posedge clk);
    endtask

    task automatic start_div_to(input int stop_cyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.op_a  = 32'd1000;
        bus.op_b  = 32'd3;
        for (int c = 1; c <= stop_cyc; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
    endtask

    initial begin
        int n_done;
        int d_cyc [2];
        logic [31:0] d_res [2];
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 3'b000;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   32'(bus.busy),  32'd0);
        chk("rst_stall",  32'(bus.stall), 32'd0);
        chk("rst_done",   32'(bus.done),  32'd0);
        chk("rst_result", bus.result,     32'd0);
        rst_n = 1'b1;

        run_op("mul_7_m3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run_op("mulhu_ff",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run_op("mulh_ff",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
        run_op("mulhsu_m1_2",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);
        run_op("mulhu_big",    3'b011, 32'h80000000, 32'd4,        32'h00000002, 34);
        run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
        run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34);
        run_op("divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       34);
        run_op("remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,        34);
        run_op("divu_by0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, EO_CYC);
        run_op("rem_by0",      3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, EO_CYC);
        run_op("div_by0",      3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, EO_CYC);
        run_op("mul_zero_a",   3'b000, 32'd0,        32'd5,        32'd0,        EO_CYC);

        // flush at cycle 10 of a DIV
        start_div_to(10);
        bus.flush = 1'b1;
        #1;
        chk("fl_stall_same", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("fl_busy", 32'(bus.busy),  32'd0);
        chk("fl_stall", 32'(bus.stall), 32'd0);
        chk("fl_done", 32'(bus.done),  32'd0);
        @(posedge clk);
        #1;
        chk("fl_done2", 32'(bus.done), 32'd0);
        run_op("mul_after_fl", 3'b000, 32'd6, 32'd7, 32'd42, 34);

        // reset in the middle of CALC
        start_div_to(10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_busy",   32'(bus.busy),  32'd0);
        chk("mrst_stall",  32'(bus.stall), 32'd0);
        chk("mrst_done",   32'(bus.done),  32'd0);
        chk("mrst_result", bus.result,     32'd0);
        rst_n = 1'b1;
        run_op("mul_after_rst", 3'b000, 32'd9, 32'd9, 32'd81, 34);

        // start held across two back-to-back MULs
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.op_a  = 32'd3;
        bus.op_b  = 32'd4;
        n_done = 0;
        d_cyc = '{-1, -1};
        d_res = '{32'd0, 32'd0};
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            #1;
            if (c == 35) begin
                bus.op_a = 32'd5;
                bus.op_b = 32'd6;
            end
            if (bus.done) begin
                if (n_done < 2) begin
                    d_cyc[n_done] = c;
                    d_res[n_done] = bus.result;
                end
                if (c == 34) chk("b2b_stall_done", 32'(bus.stall), 32'd0);
                n_done++;
                if (n_done == 2) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("b2b_cyc1",   32'(d_cyc[0]), 32'd34);
        chk("b2b_res1",   d_res[0],      32'd12);
        chk("b2b_cyc2",   32'(d_cyc[1]), 32'd69);
        chk("b2b_res2",   d_res[1],      32'd30);
        chk("b2b_ndone",  32'(n_done),   32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
